// File: rtl/dac_cmd_dispatch_pkg.sv
// Command word layout, opcodes and FSM state encoding for the DAC command dispatcher.
// Shared by the dispatcher top and its hold-off counter.
package dac_cmd_dispatch_pkg;

  localparam int CMD_W = 32;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_WRITE   = 2'b01,
    OP_BCAST   = 2'b10,
    OP_SETHOLD = 2'b11
  } opcode_t;

  // Field order from MSB: [31:30] op, [29:24] ch, [23:18] timer, [17:16] rsvd, [15:0] value
  typedef struct packed {
    opcode_t     op;
    logic [5:0]  ch;
    logic [5:0]  timer;
    logic [1:0]  rsvd;
    logic [15:0] value;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_CAPTURE,
    ST_DECODE,
    ST_WAIT,
    ST_LOAD,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/dac_cmd_dispatch_holdoff_counter.sv
// Down-counter timing the gap after a DAC load; done is high while at most one cycle remains.
// Loaded on the LOAD->HOLD transition, decrements only while enabled, no backpressure.
module dac_cmd_dispatch_holdoff_counter #(
  parameter int HOLDW = 16
) (
  input  logic             bitclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [HOLDW-1:0] load_val,
  output logic             done
);

  logic [HOLDW-1:0] cnt_q;

  always_ff @(posedge bitclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - HOLDW'(1);
    end
  end

  // A load value of N gives exactly N HOLD cycles: exit is taken on the cycle holding 1.
  assign done = (cnt_q <= HOLDW'(1));

endmodule

// File: rtl/dac_cmd_dispatch.sv
// Pops 32-bit command words from the USB FIFO and issues one-cycle load strobes to idle DAC drivers.
// Pop-to-strobe is 4 cycles with the target free; one command in flight, stalls in WAIT while busy.
module dac_cmd_dispatch
  import dac_cmd_dispatch_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int HOLDW = 16
) (
  input  logic             bitclk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rdreq,
  input  logic [NCH-1:0]   dac_busy,
  output logic [NCH-1:0]   dac_load,
  output logic [15:0]      dac_value,
  output logic [5:0]       dac_timer,
  output logic [5:0]       last_ch,
  output logic [7:0]       bad_cmd_cnt,
  output logic             idle
);

  localparam logic [6:0] NCH_W = 7'(NCH);

  state_t           state_q;
  state_t           state_d;
  cmd_t             cmd_q;
  logic [5:0]       target_q;
  logic [HOLDW-1:0] holdoff_q;
  logic [NCH-1:0]   tgt_hot;
  logic             busy_sel;
  logic             ch_valid;
  logic             more;
  logic             hold_load;
  logic             hold_done;
  logic             unused_rsvd;

  assign unused_rsvd = ^cmd_q.rsvd;
  assign ch_valid    = ({1'b0, cmd_q.ch} < NCH_W);
  assign more        = (cmd_q.op == OP_BCAST) && ({1'b0, target_q} < (NCH_W - 7'd1));

  always_comb begin
    tgt_hot = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt_hot[i] = (target_q == 6'(i));
    end
  end

  assign busy_sel = |(dac_busy & tgt_hot);
  assign dac_load = (state_q == ST_LOAD) ? tgt_hot : '0;
  assign idle     = (state_q == ST_IDLE);

  always_ff @(posedge bitclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fifo_rdreq = 1'b0;
    hold_load  = 1'b0;
    case (state_q)
      ST_IDLE:    if (!fifo_empty) state_d = ST_POP;
      ST_POP: begin
        fifo_rdreq = 1'b1;
        state_d    = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_DECODE;
      ST_DECODE: begin
        case (cmd_q.op)
          OP_WRITE: state_d = ch_valid ? ST_WAIT : ST_IDLE;
          OP_BCAST: state_d = ST_WAIT;
          default:  state_d = ST_IDLE;
        endcase
      end
      ST_WAIT:    if (!busy_sel) state_d = ST_LOAD;
      ST_LOAD: begin
        if (holdoff_q != '0) begin
          state_d   = ST_HOLD;
          hold_load = 1'b1;
        end else begin
          state_d = more ? ST_WAIT : ST_IDLE;
        end
      end
      ST_HOLD:    if (hold_done) state_d = more ? ST_WAIT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bitclk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      target_q    <= '0;
      holdoff_q   <= '0;
      dac_value   <= '0;
      dac_timer   <= '0;
      last_ch     <= '0;
      bad_cmd_cnt <= '0;
    end else begin
      if (state_q == ST_CAPTURE) begin
        cmd_q <= cmd_t'(fifo_data);
      end
      if (state_q == ST_DECODE) begin
        if (cmd_q.op == OP_SETHOLD) begin
          holdoff_q <= HOLDW'(cmd_q.value);
        end
        if ((cmd_q.op == OP_WRITE) && !ch_valid && (bad_cmd_cnt != 8'hFF)) begin
          bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
        end
        target_q <= (cmd_q.op == OP_BCAST) ? 6'd0 : cmd_q.ch;
      end
      // Output registers change on the same edge that raises the strobe.
      if ((state_q == ST_WAIT) && (state_d == ST_LOAD)) begin
        dac_value <= cmd_q.value;
        dac_timer <= cmd_q.timer;
        last_ch   <= target_q;
      end
      if (((state_q == ST_LOAD) || (state_q == ST_HOLD)) && (state_d == ST_WAIT)) begin
        target_q <= target_q + 6'd1;
      end
    end
  end

  dac_cmd_dispatch_holdoff_counter #(
    .HOLDW(HOLDW)
  ) u_holdoff (
    .bitclk  (bitclk),
    .rst_n   (rst_n),
    .load    (hold_load),
    .en      (state_q == ST_HOLD),
    .load_val(holdoff_q),
    .done    (hold_done)
  );

endmodule

// File: tb/tb_dac_cmd_dispatch.sv
// Self-checking bench for dac_cmd_dispatch: FIFO model, strobe monitor and a command-level reference model.
module tb_dac_cmd_dispatch;

  localparam int NCH   = 8;
  localparam int HOLDW = 16;

  logic           bitclk = 1'b0;
  logic           rst_n = 1'b0;
  logic [31:0]    fifo_data = '0;
  logic           fifo_empty = 1'b1;
  logic           fifo_rdreq;
  logic [NCH-1:0] dac_busy = '0;
  logic [NCH-1:0] dac_load;
  logic [15:0]    dac_value;
  logic [5:0]     dac_timer;
  logic [5:0]     last_ch;
  logic [7:0]     bad_cmd_cnt;
  logic           idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] fq[$];
  int ev_cyc[$], ev_ch[$], ev_val[$], ev_tmr[$], ev_last[$], rd_cyc[$];
  int onehot_err = 0;
  int busy_err = 0;
  logic [NCH-1:0] prev_busy = '0;

  dac_cmd_dispatch #(.NCH(NCH), .HOLDW(HOLDW)) dut (
    .bitclk(bitclk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq), .dac_busy(dac_busy), .dac_load(dac_load), .dac_value(dac_value),
    .dac_timer(dac_timer), .last_ch(last_ch), .bad_cmd_cnt(bad_cmd_cnt), .idle(idle)
  );

  always #5 bitclk = ~bitclk;
  always @(posedge bitclk) cyc = cyc + 1;

  // Non-show-ahead FIFO: a pop requested in one cycle presents data in the next.
  always @(posedge bitclk) begin : fifo_model
    logic take;
    take = fifo_rdreq;
    #1;
    if (take && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  end

  always @(negedge bitclk) begin : monitor
    int ch;
    if (dac_load != '0) begin
      ch = -1;
      for (int i = 0; i < NCH; i++) if (dac_load[i]) ch = i;
      if ($countones(dac_load) != 1) onehot_err++;
      if ((prev_busy & dac_load) != '0) busy_err++;
      ev_cyc.push_back(cyc); ev_ch.push_back(ch); ev_val.push_back(int'(dac_value));
      ev_tmr.push_back(int'(dac_timer)); ev_last.push_back(int'(last_ch));
    end
    if (fifo_rdreq) rd_cyc.push_back(cyc);
    prev_busy = dac_busy;
  end

  task automatic tick();
    @(posedge bitclk);
    #2;
  endtask

  task automatic clear_log();
    ev_cyc.delete(); ev_ch.delete(); ev_val.delete(); ev_tmr.delete(); ev_last.delete(); rd_cyc.delete();
  endtask

  function automatic logic [31:0] mk(input int op, input int ch, input int tmr, input int val);
    logic [1:0] rs;
    rs = 2'($urandom);
    return {2'(op), 6'(ch), 6'(tmr), rs, 16'(val)};
  endfunction

  task automatic wait_quiet(input int budget, input bit rand_busy, input string name);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < budget) begin
      tick();
      n++;
      if (rand_busy) dac_busy = NCH'($urandom & $urandom);
      if (idle && fifo_empty && fq.size() == 0) stable++; else stable = 0;
    end
    if (rand_busy) dac_busy = '0;
    checks++;
    if (stable < 3) begin errors++; $display("FAIL %s_timeout: still busy after %0d cycles", name, budget); end
  endtask

  task automatic check_rst_outputs(input string name);
    checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL %s_rdreq got %0b exp 0", name, fifo_rdreq); end
    checks++; if (dac_load !== '0) begin errors++; $display("FAIL %s_load got %h exp 0", name, dac_load); end
    checks++; if (dac_value !== 16'h0) begin errors++; $display("FAIL %s_value got %h exp 0", name, dac_value); end
    checks++; if (dac_timer !== 6'h0) begin errors++; $display("FAIL %s_timer got %0d exp 0", name, dac_timer); end
    checks++; if (last_ch !== 6'h0) begin errors++; $display("FAIL %s_last_ch got %0d exp 0", name, last_ch); end
    checks++; if (bad_cmd_cnt !== 8'h0) begin errors++; $display("FAIL %s_bad got %0d exp 0", name, bad_cmd_cnt); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL %s_idle got %0b exp 1", name, idle); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dac_busy = '0;
    fq.delete();
    repeat (3) tick();
    check_rst_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    clear_log();
    fq.push_back(mk(1, 3, 5, 16'h1234));
    wait_quiet(200, 1'b0, "write");
    checks++; if (ev_ch.size() != 1 || rd_cyc.size() != 1) begin
      errors++; $display("FAIL write_count strobes %0d pops %0d exp 1 1", ev_ch.size(), rd_cyc.size());
    end
    if (ev_ch.size() == 1 && rd_cyc.size() == 1) begin
      checks++; if (ev_cyc[0] - rd_cyc[0] != 4) begin errors++; $display("FAIL write_latency got %0d exp 4", ev_cyc[0] - rd_cyc[0]); end
      checks++; if (ev_ch[0] != 3) begin errors++; $display("FAIL write_ch got %0d exp 3", ev_ch[0]); end
      checks++; if (ev_val[0] != 'h1234) begin errors++; $display("FAIL write_value got %h exp 1234", ev_val[0]); end
      checks++; if (ev_tmr[0] != 5) begin errors++; $display("FAIL write_timer got %0d exp 5", ev_tmr[0]); end
      checks++; if (ev_last[0] != 3) begin errors++; $display("FAIL write_last_ch got %0d exp 3", ev_last[0]); end
    end
  endtask

  task automatic test_busy_stall();
    int n = 0;
    int drop_cyc;
    clear_log();
    dac_busy = NCH'(4);
    fq.push_back(mk(1, 2, 1, 16'h0BEE));
    while (rd_cyc.size() == 0 && n < 20) begin tick(); n++; end
    repeat (20) tick();
    checks++; if (ev_ch.size() != 0) begin errors++; $display("FAIL busy_hold strobes %0d exp 0", ev_ch.size()); end
    drop_cyc = cyc;
    dac_busy = '0;
    wait_quiet(100, 1'b0, "busy");
    checks++; if (ev_ch.size() != 1 || rd_cyc.size() != 1) begin
      errors++; $display("FAIL busy_count strobes %0d pops %0d exp 1 1", ev_ch.size(), rd_cyc.size());
    end
    if (ev_ch.size() == 1) begin
      checks++; if (ev_cyc[0] != drop_cyc + 1) begin errors++; $display("FAIL busy_release at %0d exp %0d", ev_cyc[0], drop_cyc + 1); end
      checks++; if (ev_ch[0] != 2) begin errors++; $display("FAIL busy_ch got %0d exp 2", ev_ch[0]); end
    end
  endtask

  task automatic test_bcast_holdoff();
    clear_log();
    fq.push_back(mk(3, 0, 0, 10));
    fq.push_back(mk(2, 5, 7, 16'hABCD));
    wait_quiet(1000, 1'b0, "bcast");
    checks++; if (ev_ch.size() != NCH) begin errors++; $display("FAIL bcast_count got %0d exp %0d", ev_ch.size(), NCH); end
    checks++; if (rd_cyc.size() != 2) begin errors++; $display("FAIL bcast_pops got %0d exp 2", rd_cyc.size()); end
    for (int i = 0; i < ev_ch.size(); i++) begin
      checks++; if (ev_ch[i] != i || ev_val[i] != 'hABCD || ev_tmr[i] != 7) begin
        errors++; $display("FAIL bcast_ev%0d ch %0d val %h tmr %0d exp %0d abcd 7", i, ev_ch[i], ev_val[i], ev_tmr[i], i);
      end
      if (i > 0) begin
        checks++; if (ev_cyc[i] - ev_cyc[i-1] != 12) begin
          errors++; $display("FAIL bcast_gap%0d got %0d exp 12", i, ev_cyc[i] - ev_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_bad_cmd();
    clear_log();
    fq.push_back(mk(1, 40, 0, 16'h1111));
    wait_quiet(100, 1'b0, "bad1");
    checks++; if (bad_cmd_cnt !== 8'd1) begin errors++; $display("FAIL bad_first got %0d exp 1", bad_cmd_cnt); end
    for (int i = 0; i < 300; i++) fq.push_back(mk(1, $urandom_range(NCH, 63), $urandom, $urandom));
    wait_quiet(5000, 1'b0, "bad300");
    checks++; if (bad_cmd_cnt !== 8'd255) begin errors++; $display("FAIL bad_saturate got %0d exp 255", bad_cmd_cnt); end
    checks++; if (ev_ch.size() != 0) begin errors++; $display("FAIL bad_strobes got %0d exp 0", ev_ch.size()); end
    checks++; if (rd_cyc.size() != 301) begin errors++; $display("FAIL bad_pops got %0d exp 301", rd_cyc.size()); end
  endtask

  task automatic test_nop_idle();
    clear_log();
    fq.push_back(mk(0, $urandom, $urandom, $urandom));
    repeat (50) tick();
    checks++; if (rd_cyc.size() != 1) begin errors++; $display("FAIL nop_pops got %0d exp 1", rd_cyc.size()); end
    checks++; if (ev_ch.size() != 0) begin errors++; $display("FAIL nop_strobes got %0d exp 0", ev_ch.size()); end
    checks++; if (idle !== 1'b1 || fifo_rdreq !== 1'b0) begin
      errors++; $display("FAIL nop_idle idle %0b rdreq %0b exp 1 0", idle, fifo_rdreq);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_log();
    fq.push_back(mk(3, 0, 0, 10));
    fq.push_back(mk(2, 0, 3, 16'h5A5A));
    while (ev_ch.size() < 5 && n < 500) begin tick(); n++; end
    checks++; if (ev_ch.size() != 5) begin errors++; $display("FAIL rstmid_pre strobes %0d exp 5", ev_ch.size()); end
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_rst_outputs("rstmid");
    fq.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    checks++; if (ev_ch.size() != 5) begin errors++; $display("FAIL rstmid_post strobes %0d exp 5", ev_ch.size()); end
    // Two back-to-back writes reveal whether any hold-off survived the reset.
    clear_log();
    fq.push_back(mk(1, 1, 2, 16'h0101));
    fq.push_back(mk(1, 6, 2, 16'h0606));
    wait_quiet(200, 1'b0, "b2b");
    checks++; if (ev_ch.size() != 2 || rd_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_count strobes %0d pops %0d exp 2 2", ev_ch.size(), rd_cyc.size());
    end
    if (ev_ch.size() == 2 && rd_cyc.size() == 2) begin
      checks++; if (ev_cyc[1] - ev_cyc[0] != 6) begin errors++; $display("FAIL b2b_gap got %0d exp 6", ev_cyc[1] - ev_cyc[0]); end
      checks++; if (rd_cyc[1] - ev_cyc[0] != 2) begin errors++; $display("FAIL b2b_pop got %0d exp 2", rd_cyc[1] - ev_cyc[0]); end
      checks++; if (ev_ch[0] != 1 || ev_ch[1] != 6) begin errors++; $display("FAIL b2b_ch got %0d %0d exp 1 6", ev_ch[0], ev_ch[1]); end
    end
  endtask

  task automatic test_random();
    int ex_ch[$], ex_val[$], ex_tmr[$];
    int exp_bad = 0;
    int op, ch, tmr, val;
    clear_log();
    onehot_err = 0;
    busy_err = 0;
    for (int n = 0; n < 40; n++) begin
      op  = $urandom_range(0, 3);
      ch  = $urandom_range(0, NCH + 4);
      tmr = $urandom_range(0, 63);
      val = $urandom_range(0, 65535);
      if (op == 3) val = $urandom_range(0, 3);
      fq.push_back(mk(op, ch, tmr, val));
      if (op == 1) begin
        if (ch < NCH) begin ex_ch.push_back(ch); ex_val.push_back(val); ex_tmr.push_back(tmr); end
        else if (exp_bad < 255) exp_bad++;
      end else if (op == 2) begin
        for (int c = 0; c < NCH; c++) begin ex_ch.push_back(c); ex_val.push_back(val); ex_tmr.push_back(tmr); end
      end
    end
    wait_quiet(20000, 1'b1, "random");
    checks++; if (ev_ch.size() != ex_ch.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", ev_ch.size(), ex_ch.size()); end
    for (int i = 0; i < ev_ch.size() && i < ex_ch.size(); i++) begin
      checks++; if (ev_ch[i] != ex_ch[i] || ev_val[i] != ex_val[i] || ev_tmr[i] != ex_tmr[i] || ev_last[i] != ex_ch[i]) begin
        errors++; $display("FAIL rand_ev%0d ch %0d val %h tmr %0d last %0d exp ch %0d val %h tmr %0d",
                           i, ev_ch[i], ev_val[i], ev_tmr[i], ev_last[i], ex_ch[i], ex_val[i], ex_tmr[i]);
      end
    end
    checks++; if (bad_cmd_cnt !== 8'(exp_bad)) begin errors++; $display("FAIL rand_bad got %0d exp %0d", bad_cmd_cnt, exp_bad); end
    checks++; if (onehot_err != 0) begin errors++; $display("FAIL rand_onehot got %0d exp 0", onehot_err); end
    checks++; if (busy_err != 0) begin errors++; $display("FAIL rand_busy_load got %0d exp 0", busy_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_busy_stall();
    test_bcast_holdoff();
    test_bad_cmd();
    test_nop_idle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
